// File: rtl/sd_sector_packer.sv
// Packs the SD reader's per-sector byte stream into 32-bit little-endian words and writes
// them to word-addressed memory via req/ack, buffering stalls in a small word FIFO.
module sd_sector_packer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 16,
  parameter int SECTOR_BYTES = 512
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_sectors,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic              in_crc_ok,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [2:0]        error
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(SECTOR_BYTES);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BYTE = BW'(SECTOR_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       sect_q, sect_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        err_q, err_d;
  logic              done_q, done_d;

  logic [PW-1:0]     wr_q, rd_q;
  logic [PW:0]       cnt_q;
  logic [31:0]       fifo_mem [FIFO_DEPTH];

  logic              empty, full, push, push_ok, pop;
  logic              last_byte, sector_end;
  logic [31:0]       byte_word;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign mem_req   = !empty && (state_q != S_IDLE);
  assign pop       = mem_req && mem_ack;
  assign push_ok   = push && (!full || pop);
  assign mem_addr  = addr_q;
  assign mem_wdata = empty ? 32'h0 : fifo_mem[rd_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign error     = err_q;

  assign last_byte  = (bcnt_q == LAST_BYTE);
  assign sector_end = in_last || last_byte;
  // Merge the incoming byte into its lane; lanes above it are still zero, which pads partial words.
  assign byte_word  = word_q | ({24'h0, in_data} << {bcnt_q[1:0], 3'b000});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sect_d  = sect_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;

    if (pop) addr_d = addr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          sect_d = num_sectors;
          bcnt_d = '0;
          word_d = '0;
          err_d  = '0;
          if (num_sectors != 16'd0) state_d = S_RUN;
          else                      done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (sector_end || bcnt_q[1:0] == 2'd3) begin
            push   = 1'b1;
            word_d = '0;
          end else begin
            word_d = byte_word;
          end
          bcnt_d = sector_end ? '0 : bcnt_q + 1'b1;
          if (in_last != last_byte)   err_d[1] = 1'b1;
          if (in_last && !in_crc_ok)  err_d[2] = 1'b1;
          if (sector_end) begin
            sect_d = sect_q - 16'd1;
            if (sect_q == 16'd1) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push && !push_ok) err_d[0] = 1'b1;
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      sect_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sect_q  <= sect_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      done_q  <= done_d;
      wr_q    <= wr_q + PW'(push_ok);
      rd_q    <= rd_q + PW'(pop);
      cnt_q   <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q and the output is masked when empty.
  always_ff @(posedge clk_25mhz) begin
    if (push_ok) fifo_mem[wr_q] <= byte_word;
  end

endmodule

// File: tb/tb_sd_sector_packer.sv
// Directed + randomized bench for sd_sector_packer; expected words come from a byte-list
// packing model and are compared against writes captured at the memory port.
module tb_sd_sector_packer;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_sectors;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_crc_ok;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [2:0]  error;

  int tests = 0;
  int fails = 0;
  int ack_mode = 0;   // 0: never ack, 1: ack every request, 2: random ack
  int done_cnt = 0;
  int busy_cnt = 0;
  int req_cnt  = 0;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  bytes_q[$];
  logic [31:0] exp_q[$];

  always #20 clk_25mhz = ~clk_25mhz;

  sd_sector_packer #(.FIFO_DEPTH(8), .ADDR_W(16), .SECTOR_BYTES(512)) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .num_sectors(num_sectors),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_crc_ok  (in_crc_ok),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Memory responder and event counters; a write is logged when the ack is committed.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_25mhz);
      if (rst_n === 1'b1 && mem_req === 1'b1 &&
          (ack_mode == 1 || (ack_mode == 2 && $urandom_range(2) != 0))) begin
        mem_ack = 1'b1;
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wdata);
      end else begin
        mem_ack = 1'b0;
      end
      if (done === 1'b1)    done_cnt++;
      if (busy === 1'b1)    busy_cnt++;
      if (mem_req === 1'b1) req_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] base, input logic [15:0] nsec);
    base_addr   = base;
    num_sectors = nsec;
    start       = 1'b1;
    @(negedge clk_25mhz);
    start       = 1'b0;
  endtask

  // in_last marks byte index last_idx within every 512-byte sector (-1: never).
  task automatic send_bytes(input int last_idx, input bit crc, input bit gaps);
    for (int i = 0; i < bytes_q.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk_25mhz);
        end
      end
      in_valid  = 1'b1;
      in_data   = bytes_q[i];
      in_last   = ((i % 512) == last_idx);
      in_crc_ok = crc;
      @(negedge clk_25mhz);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic random_bytes(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk_25mhz);
    repeat (4) @(negedge clk_25mhz);
    check({tag, "_done_count"}, 32'(done_cnt), 32'(target));
  endtask

  // Reference: little-endian packing of the byte list, final partial word zero-padded.
  task automatic build_exp(input int max_words);
    logic [31:0] w;
    exp_q.delete();
    w = 32'h0;
    for (int i = 0; i < bytes_q.size(); i++) begin
      w = w | (32'(bytes_q[i]) << (8 * (i % 4)));
      if ((i % 4) == 3 || i == bytes_q.size() - 1) begin
        exp_q.push_back(w);
        w = 32'h0;
      end
    end
    while (max_words >= 0 && exp_q.size() > max_words) void'(exp_q.pop_back());
  endtask

  task automatic check_writes(input string tag, input logic [15:0] base);
    logic [15:0] ea;
    check({tag, "_nwrites"}, 32'(wd_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wd_q.size(); i++) begin
      ea = base + 16'(i);
      check($sformatf("%s_data[%0d]", tag, i), wd_q[i], exp_q[i]);
      check($sformatf("%s_addr[%0d]", tag, i), 32'(wa_q[i]), 32'(ea));
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    logic [15:0] base;
    int          dc;
    int          bc;
    int          rc;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_sectors = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_crc_ok = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_25mhz);

    // 1: counting pattern, immediate ack
    clear_log(); ack_mode = 1;
    bytes_q.delete();
    for (int i = 0; i < 512; i++) bytes_q.push_back(8'(i % 256));
    do_start(16'h0100, 16'd1);
    check("t1_busy", 32'(busy), 32'd1);
    send_bytes(511, 1'b1, 1'b0);
    wait_done("t1", 1, 200);
    build_exp(-1);
    check_writes("t1", 16'h0100);
    check("t1_first", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'h03020100);
    check("t1_last", wd_q.size() > 0 ? wd_q[wd_q.size()-1] : 32'hx, 32'hFFFEFDFC);
    check("t1_error", 32'(error), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // 2: memory stalled for a whole sector -> FIFO-depth words kept, rest dropped
    clear_log(); ack_mode = 0;
    random_bytes(512);
    base = 16'($urandom);
    do_start(base, 16'd1);
    send_bytes(511, 1'b1, 1'b0);
    check("t2_req_stalled", 32'(mem_req), 32'd1);
    check("t2_no_writes_yet", 32'(wd_q.size()), 32'd0);
    ack_mode = 1;
    wait_done("t2", 2, 200);
    build_exp(8);
    check_writes("t2", base);
    check("t2_error", 32'(error), 32'd1);

    // 3: short sector, in_last on byte 6
    clear_log(); ack_mode = 1;
    bytes_q.delete();
    for (int i = 0; i < 7; i++) bytes_q.push_back(8'(8'h10 + i));
    do_start(16'h0040, 16'd1);
    send_bytes(6, 1'b1, 1'b0);
    wait_done("t3", 3, 100);
    build_exp(-1);
    check_writes("t3", 16'h0040);
    check("t3_w1", wd_q.size() > 1 ? wd_q[1] : 32'hx, 32'h00161514);
    check("t3_error", 32'(error), 32'd2);

    // 4: zero sectors
    clear_log();
    bc = busy_cnt; rc = req_cnt;
    base_addr = 16'h1234; num_sectors = 16'd0; start = 1'b1;
    @(negedge clk_25mhz);
    start = 1'b0;
    check("t4_done_pulse", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk_25mhz);
    check("t4_done_clear", 32'(done), 32'd0);
    repeat (3) @(negedge clk_25mhz);
    check("t4_busy_never", 32'(busy_cnt), 32'(bc));
    check("t4_req_never", 32'(req_cnt), 32'(rc));
    check("t4_error", 32'(error), 32'd0);

    // 5: address wrap, bad CRC, random ack and byte gaps
    clear_log(); ack_mode = 2;
    random_bytes(512);
    do_start(16'hFFFE, 16'd1);
    send_bytes(511, 1'b0, 1'b1);
    wait_done("t5", 5, 400);
    build_exp(-1);
    check_writes("t5", 16'hFFFE);
    check("t5_error", 32'(error), 32'd4);

    // 7: two random sectors, random base, random ack and gaps
    clear_log(); ack_mode = 2;
    random_bytes(1024);
    base = 16'($urandom);
    do_start(base, 16'd2);
    send_bytes(511, 1'b1, 1'b1);
    wait_done("t7", 6, 400);
    build_exp(-1);
    check_writes("t7", base);
    check("t7_error", 32'(error), 32'd0);

    // 6: reset mid-sector with a request pending and overflow flagged
    clear_log(); ack_mode = 0;
    random_bytes(40);
    do_start(16'h0200, 16'd1);
    send_bytes(-1, 1'b1, 1'b0);
    check("t6_req_pre", 32'(mem_req), 32'd1);
    check("t6_err_pre", 32'(error), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_req_rst", 32'(mem_req), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_err_rst", 32'(error), 32'd0);
    @(negedge clk_25mhz);
    rst_n = 1'b1;
    @(negedge clk_25mhz);
    clear_log(); ack_mode = 1;
    random_bytes(512);
    dc = done_cnt;
    do_start(16'h0300, 16'd1);
    send_bytes(511, 1'b1, 1'b0);
    wait_done("t6", dc + 1, 200);
    build_exp(-1);
    check_writes("t6", 16'h0300);
    check("t6_error", 32'(error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
